vram_arbiter: RTL and testbench

Sequences the single external video-memory port between two requesters: the scanline fetch path (video, read-only, time-critical) and the host port (read/write). Runs each granted access as a fixed-length strobe cycle on the memory pins, then returns data or an acknowledge to the winner. Sits between the scanout/host logic and the SRAM pin interface. Video has priority, with a bounded-starvation guarantee for the host.

---
 rtl/vram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: sequences the shared video-memory port between the scanline
// fetch path (video, read-only, priority) and the host port (read/write).
// Each grant runs a fixed WAIT-cycle strobe, then one RECOVER cycle that
// carries the completion pulse. Host starvation is bounded by VMAX.
module vram_arbiter #(
    parameter int unsigned A    = 18,
    parameter int unsigned P    = 1,
    parameter int unsigned WAIT = 2,
    parameter int unsigned VMAX = 4
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         VidReq,
    input  logic [A-1:0] VidAddress,
    input  logic [P-1:0] VidPage,
    output logic [7:0]   VidData,
    output logic         VidValid,
    input  logic         HostReq,
    input  logic         HostWrite,
    input  logic [A-1:0] HostAddress,
    input  logic [P-1:0] HostPage,
    input  logic [7:0]   HostDataIn,
    output logic [7:0]   HostDataOut,
    output logic         HostAck,
    output logic [A-1:0] MemAddress,
    output logic [P-1:0] MemPageMux,
    output logic [7:0]   MemDataOut,
    input  logic [7:0]   MemDataIn,
    output logic         MemRead,
    output logic         MemWrite
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT - 1);
    localparam logic [3:0] VMAX_L    = 4'(VMAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID_ACCESS,
        ST_HOST_ACCESS,
        ST_RECOVER
    } state_t;

    state_t       state_q,      state_d;
    logic [3:0]   wait_q,       wait_d;
    logic [3:0]   streak_q,     streak_d;
    logic         host_write_q, host_write_d;
    logic [A-1:0] mem_addr_q,   mem_addr_d;
    logic [P-1:0] mem_page_q,   mem_page_d;
    logic [7:0]   mem_dout_q,   mem_dout_d;
    logic         mem_read_q,   mem_read_d;
    logic         mem_write_q,  mem_write_d;
    logic [7:0]   vid_data_q,   vid_data_d;
    logic         vid_valid_q,  vid_valid_d;
    logic [7:0]   host_dout_q,  host_dout_d;
    logic         host_ack_q,   host_ack_d;

    // Next-state: grant decision in IDLE, strobe countdown in ACCESS, capture at the last ACCESS edge
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        streak_d     = streak_q;
        host_write_d = host_write_q;
        mem_addr_d   = mem_addr_q;
        mem_page_d   = mem_page_q;
        mem_dout_d   = mem_dout_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        vid_data_d   = vid_data_q;
        vid_valid_d  = 1'b0;
        host_dout_d  = host_dout_q;
        host_ack_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Video wins a tie unless it has already used its streak allowance
                if (VidReq && !(HostReq && streak_q == VMAX_L)) begin
                    state_d     = ST_VID_ACCESS;
                    wait_d      = WAIT_INIT;
                    mem_addr_d  = VidAddress;
                    mem_page_d  = VidPage;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    if (!HostReq)
                        streak_d = '0;
                    else if (streak_q != VMAX_L)
                        streak_d = streak_q + 4'd1;
                end else if (HostReq) begin
                    state_d      = ST_HOST_ACCESS;
                    wait_d       = WAIT_INIT;
                    streak_d     = '0;
                    host_write_d = HostWrite;
                    mem_addr_d   = HostAddress;
                    mem_page_d   = HostPage;
                    mem_read_d   = !HostWrite;
                    mem_write_d  = HostWrite;
                    if (HostWrite)
                        mem_dout_d = HostDataIn;
                end
            end
            ST_VID_ACCESS: begin
                if (wait_q == '0) begin
                    state_d     = ST_RECOVER;
                    mem_read_d  = 1'b0;
                    vid_data_d  = MemDataIn;
                    vid_valid_d = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_HOST_ACCESS: begin
                if (wait_q == '0) begin
                    state_d     = ST_RECOVER;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    host_ack_d  = 1'b1;
                    if (!host_write_q)
                        host_dout_d = MemDataIn;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops strobes and pulses immediately
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            streak_q     <= '0;
            host_write_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_page_q   <= '0;
            mem_dout_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            vid_data_q   <= '0;
            vid_valid_q  <= 1'b0;
            host_dout_q  <= '0;
            host_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            streak_q     <= streak_d;
            host_write_q <= host_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_page_q   <= mem_page_d;
            mem_dout_q   <= mem_dout_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
            host_dout_q  <= host_dout_d;
            host_ack_q   <= host_ack_d;
        end
    end

    assign VidData     = vid_data_q;
    assign VidValid    = vid_valid_q;
    assign HostDataOut = host_dout_q;
    assign HostAck     = host_ack_q;
    assign MemAddress  = mem_addr_q;
    assign MemPageMux  = mem_page_q;
    assign MemDataOut  = mem_dout_q;
    assign MemRead     = mem_read_q;
    assign MemWrite    = mem_write_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: table of single accesses plus hand-written
// sequences for streak fairness, simultaneous requests and mid-access reset.
module tb_vram_arbiter;

    localparam int unsigned A_C    = 18;
    localparam int unsigned P_C    = 1;
    localparam int unsigned WAIT_C = 2;
    localparam int unsigned VMAX_C = 4;

    logic           Clk = 1'b0;
    logic           ResetN;
    logic           VidReq;
    logic [A_C-1:0] VidAddress;
    logic [P_C-1:0] VidPage;
    logic [7:0]     VidData;
    logic           VidValid;
    logic           HostReq;
    logic           HostWrite;
    logic [A_C-1:0] HostAddress;
    logic [P_C-1:0] HostPage;
    logic [7:0]     HostDataIn;
    logic [7:0]     HostDataOut;
    logic           HostAck;
    logic [A_C-1:0] MemAddress;
    logic [P_C-1:0] MemPageMux;
    logic [7:0]     MemDataOut;
    logic [7:0]     MemDataIn;
    logic           MemRead;
    logic           MemWrite;

    int checks = 0;
    int errors = 0;

    vram_arbiter #(
        .A    (A_C),
        .P    (P_C),
        .WAIT (WAIT_C),
        .VMAX (VMAX_C)
    ) dut (
        .Clk         (Clk),
        .ResetN      (ResetN),
        .VidReq      (VidReq),
        .VidAddress  (VidAddress),
        .VidPage     (VidPage),
        .VidData     (VidData),
        .VidValid    (VidValid),
        .HostReq     (HostReq),
        .HostWrite   (HostWrite),
        .HostAddress (HostAddress),
        .HostPage    (HostPage),
        .HostDataIn  (HostDataIn),
        .HostDataOut (HostDataOut),
        .HostAck     (HostAck),
        .MemAddress  (MemAddress),
        .MemPageMux  (MemPageMux),
        .MemDataOut  (MemDataOut),
        .MemDataIn   (MemDataIn),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic           vreq;
        logic           hreq;
        logic           hwr;
        logic [A_C-1:0] vaddr;
        logic [P_C-1:0] vpage;
        logic [A_C-1:0] haddr;
        logic [P_C-1:0] hpage;
        logic [7:0]     hdin;
        logic [7:0]     mdin;
        logic           exp_vid;
        logic           exp_wr;
        logic [A_C-1:0] exp_addr;
        logic [P_C-1:0] exp_page;
        logic [7:0]     exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobes must never overlap
    always @(negedge Clk) begin
        if (ResetN === 1'b1)
            chk("strobe_overlap", 32'(MemRead & MemWrite), 32'd0);
    end

    // Called in an IDLE cycle with requests already driven; returns at the RECOVER-cycle sample
    task automatic expect_access(input string tag, input logic exp_vid, input logic exp_wr,
                                 input logic [A_C-1:0] exp_addr, input logic [P_C-1:0] exp_page,
                                 input logic [7:0] exp_dout, input logic [7:0] exp_rdata);
        int unsigned n = 0;
        @(negedge Clk);
        while (!(MemRead || MemWrite) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_grant"}, 32'(MemRead | MemWrite), 32'd1);
        for (int unsigned i = 0; i < WAIT_C; i++) begin
            if (i != 0) @(negedge Clk);
            chk({tag, "_strobe"}, 32'({MemWrite, MemRead}), exp_wr ? 32'd2 : 32'd1);
            chk({tag, "_addr"}, 32'(MemAddress), 32'(exp_addr));
            chk({tag, "_page"}, 32'(MemPageMux), 32'(exp_page));
            chk({tag, "_pulse_early"}, 32'({VidValid, HostAck}), 32'd0);
            if (exp_wr)
                chk({tag, "_wdata"}, 32'(MemDataOut), 32'(exp_dout));
        end
        @(negedge Clk);
        chk({tag, "_recover_strobe"}, 32'({MemWrite, MemRead}), 32'd0);
        chk({tag, "_vid_valid"}, 32'(VidValid), 32'(exp_vid));
        chk({tag, "_host_ack"}, 32'(HostAck), 32'(!exp_vid));
        if (exp_vid)
            chk({tag, "_vid_data"}, 32'(VidData), 32'(exp_rdata));
        else if (!exp_wr)
            chk({tag, "_host_rdata"}, 32'(HostDataOut), 32'(exp_rdata));
    endtask

    initial begin
        //           vreq hreq hwr vaddr       vp   haddr       hp   hdin   mdin   vid  wr   exp_addr    ep   rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 18'h12345, 1'b1, 18'h00000, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 18'h12345, 1'b1, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 18'h00000, 1'b0, 18'h00010, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, 18'h00010, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 18'h00010, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 18'h00010, 1'b0, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 18'h2AAAA, 1'b0, 18'h15555, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 18'h2AAAA, 1'b0, 8'h5A};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 18'h3FFFF, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 18'h3FFFF, 1'b1, 8'hFF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 18'h00000, 1'b0, 18'h3FFFF, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 18'h00000, 1'b0, 8'h00};

        ResetN = 1'b0;
        VidReq = 1'b0; VidAddress = '0; VidPage = '0;
        HostReq = 1'b0; HostWrite = 1'b0; HostAddress = '0; HostPage = '0; HostDataIn = '0;
        MemDataIn = '0;

        // Reset state
        #12;
        chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
        chk("rst_pulses", 32'({VidValid, HostAck}), 32'd0);
        chk("rst_mem_addr", 32'(MemAddress), 32'd0);
        chk("rst_mem_page", 32'(MemPageMux), 32'd0);
        chk("rst_mem_dout", 32'(MemDataOut), 32'd0);
        chk("rst_vid_data", 32'(VidData), 32'd0);
        chk("rst_host_dout", 32'(HostDataOut), 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("idle_strobes", 32'({MemRead, MemWrite}), 32'd0);
        end
        @(posedge Clk); #1;

        // Table of single accesses
        for (int i = 0; i < 6; i++) begin
            VidReq      = vecs[i].vreq;
            HostReq     = vecs[i].hreq;
            HostWrite   = vecs[i].hwr;
            VidAddress  = vecs[i].vaddr;
            VidPage     = vecs[i].vpage;
            HostAddress = vecs[i].haddr;
            HostPage    = vecs[i].hpage;
            HostDataIn  = vecs[i].hdin;
            MemDataIn   = vecs[i].mdin;
            expect_access($sformatf("vec%0d", i), vecs[i].exp_vid, vecs[i].exp_wr,
                          vecs[i].exp_addr, vecs[i].exp_page, vecs[i].hdin, vecs[i].exp_rdata);
            @(posedge Clk); #1;
            VidReq = 1'b0;
            HostReq = 1'b0;
        end

        // Both held high: VMAX video grants then one host grant, repeating
        VidReq = 1'b1; VidAddress = 18'h01234; VidPage = 1'b0;
        HostReq = 1'b1; HostWrite = 1'b0; HostAddress = 18'h00ABC; HostPage = 1'b1;
        MemDataIn = 8'h77;
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) != 4)
                expect_access($sformatf("starve%0d_V", i), 1'b1, 1'b0, 18'h01234, 1'b0, 8'h00, 8'h77);
            else
                expect_access($sformatf("starve%0d_H", i), 1'b0, 1'b0, 18'h00ABC, 1'b1, 8'h00, 8'h77);
        end
        @(posedge Clk); #1;
        VidReq = 1'b0; HostReq = 1'b0;

        // Simultaneous request with streak cleared; mid-access input changes ignored
        VidReq = 1'b1; VidAddress = 18'h0F0F0; VidPage = 1'b1;
        HostReq = 1'b1; HostWrite = 1'b0; HostAddress = 18'h00100; HostPage = 1'b0;
        MemDataIn = 8'h11;
        @(negedge Clk);
        chk("sim_idle_strobe", 32'(MemRead), 32'd0);
        @(posedge Clk); #1;
        HostAddress = 18'h3C3C3;
        VidReq = 1'b0;
        @(negedge Clk);
        chk("sim_vid_wins", 32'({MemWrite, MemRead}), 32'd1);
        chk("sim_addr_c1", 32'(MemAddress), 32'h0F0F0);
        chk("sim_page_c1", 32'(MemPageMux), 32'd1);
        @(negedge Clk);
        chk("sim_strobe_c2", 32'(MemRead), 32'd1);
        chk("sim_addr_c2", 32'(MemAddress), 32'h0F0F0);
        @(posedge Clk); #1;
        MemDataIn = 8'h22;
        @(negedge Clk);
        chk("sim_recover_strobes", 32'({MemRead, MemWrite}), 32'd0);
        chk("sim_vid_valid", 32'(VidValid), 32'd1);
        chk("sim_vid_data", 32'(VidData), 32'h11);
        @(negedge Clk);
        chk("sim_idle_after_recover", 32'({MemRead, MemWrite}), 32'd0);
        chk("sim_valid_one_cycle", 32'(VidValid), 32'd0);
        @(negedge Clk);
        chk("sim_host_grant", 32'({MemWrite, MemRead}), 32'd1);
        chk("sim_host_addr", 32'(MemAddress), 32'h3C3C3);
        chk("sim_host_page", 32'(MemPageMux), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        chk("sim_host_ack", 32'(HostAck), 32'd1);
        chk("sim_host_rdata", 32'(HostDataOut), 32'h22);
        chk("sim_vid_data_held", 32'(VidData), 32'h11);
        @(posedge Clk); #1;
        HostReq = 1'b0;

        // Reset in the second ACCESS cycle aborts the access without a pulse
        VidReq = 1'b1; VidAddress = 18'h00055; VidPage = 1'b0;
        MemDataIn = 8'h99;
        begin
            int unsigned n = 0;
            @(negedge Clk);
            while (!MemRead && n < 40) begin
                @(negedge Clk);
                n++;
            end
            chk("rstmid_grant", 32'(MemRead), 32'd1);
        end
        @(posedge Clk); #1;
        ResetN = 1'b0;
        #1;
        chk("rstmid_read_drop", 32'(MemRead), 32'd0);
        chk("rstmid_addr", 32'(MemAddress), 32'd0);
        chk("rstmid_vid_data", 32'(VidData), 32'd0);
        chk("rstmid_host_dout", 32'(HostDataOut), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("rstmid_no_valid", 32'({VidValid, HostAck, MemRead, MemWrite}), 32'd0);
        end
        ResetN = 1'b1;
        @(negedge Clk);
        chk("rstmid_regrant", 32'(MemRead), 32'd1);
        chk("rstmid_regrant_addr", 32'(MemAddress), 32'h00055);
        @(negedge Clk);
        @(negedge Clk);
        chk("rstmid_valid", 32'(VidValid), 32'd1);
        chk("rstmid_data", 32'(VidData), 32'h99);
        @(posedge Clk); #1;
        VidReq = 1'b0;
        repeat (2) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
